// File: rtl/hwpe_stream_mux_arbiter.sv
// Burst-locking round-robin arbiter that drives the select of a static two-input stream mux.
// A grant holds the mux on one input until the latched number of beats has passed.
module hwpe_stream_mux_arbiter #(
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   enable_i,
  input  logic [BURST_WIDTH-1:0] burst_len_i,
  input  logic                   req_0_i,
  input  logic                   req_1_i,
  input  logic                   pop_valid_i,
  input  logic                   pop_ready_i,
  output logic                   sel_o,
  output logic                   locked_o,
  output logic [BURST_WIDTH-1:0] beat_cnt_o,
  output logic                   burst_done_o
);

  localparam logic IDLE = 1'b0;
  localparam logic LOCK = 1'b1;

  logic                   state_q, state_d;
  logic                   sel_q, sel_d;
  logic                   last_grant_q, last_grant_d;
  logic                   burst_done_q, burst_done_d;
  logic [BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [BURST_WIDTH-1:0] len_q, len_d;

  logic beat, last_beat, grant_idx;

  assign beat      = (state_q == LOCK) && pop_valid_i && pop_ready_i;
  assign last_beat = beat && (beat_cnt_q == len_q - BURST_WIDTH'(1));
  // Under contention the input that did not win last time gets the mux.
  assign grant_idx = (req_0_i && req_1_i) ? ~last_grant_q : req_1_i;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    burst_done_d = 1'b0;
    if (clear_i) begin
      state_d      = IDLE;
      sel_d        = 1'b0;
      beat_cnt_d   = '0;
      last_grant_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && (req_0_i || req_1_i)) begin
            state_d      = LOCK;
            sel_d        = grant_idx;
            last_grant_d = grant_idx;
            beat_cnt_d   = '0;
            len_d        = (burst_len_i == '0) ? BURST_WIDTH'(1) : burst_len_i;
          end
        end
        default: begin
          // Count reaches len_q on the final beat; len_q <= 2^W-1 so it cannot wrap.
          if (beat) beat_cnt_d = beat_cnt_q + BURST_WIDTH'(1);
          if (last_beat) begin
            state_d      = IDLE;
            burst_done_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      len_q        <= BURST_WIDTH'(1);
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign sel_o        = sel_q;
  assign locked_o     = state_q;
  assign beat_cnt_o   = beat_cnt_q;
  assign burst_done_o = burst_done_q;

endmodule

// File: tb/tb_hwpe_stream_mux_arbiter.sv
// Directed bench for hwpe_stream_mux_arbiter: inputs change and outputs are sampled 1ns after each rising edge.
module tb_hwpe_stream_mux_arbiter;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_ni, clear_i, enable_i;
  logic [BW-1:0] burst_len_i;
  logic          req_0_i, req_1_i, pop_valid_i, pop_ready_i;
  logic          sel_o, locked_o, burst_done_o;
  logic [BW-1:0] beat_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hwpe_stream_mux_arbiter #(.BURST_WIDTH(BW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .enable_i(enable_i),
    .burst_len_i(burst_len_i), .req_0_i(req_0_i), .req_1_i(req_1_i),
    .pop_valid_i(pop_valid_i), .pop_ready_i(pop_ready_i),
    .sel_o(sel_o), .locked_o(locked_o), .beat_cnt_o(beat_cnt_o),
    .burst_done_o(burst_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic sl,
                         input logic [BW-1:0] cnt, input logic dn);
    chk({tag, ".locked"}, 32'(locked_o), 32'(lk));
    chk({tag, ".sel"}, 32'(sel_o), 32'(sl));
    chk({tag, ".cnt"}, 32'(beat_cnt_o), 32'(cnt));
    chk({tag, ".done"}, 32'(burst_done_o), 32'(dn));
  endtask

  initial begin
    logic [BW-1:0] bp_cnt [5];
    logic          bp_rdy [5];
    bp_cnt = '{1, 1, 1, 2, 3};
    bp_rdy = '{1, 0, 0, 1, 1};

    rst_ni = 0; clear_i = 0; enable_i = 1; burst_len_i = 4;
    req_0_i = 0; req_1_i = 0; pop_valid_i = 1; pop_ready_i = 1;
    tick();
    chk_all("reset", 0, 0, 0, 0);
    rst_ni = 1;

    // Single requester, burst of 4; handshake in the requesting IDLE cycle is not a beat.
    req_0_i = 1;
    tick();
    chk_all("single.grant", 1, 0, 0, 0);
    req_0_i = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all("single.beat", 1, 0, BW'(i), 0);
    end
    tick();
    chk_all("single.end", 0, 0, 4, 1);
    tick();
    chk_all("single.idle", 0, 0, 4, 0);

    clear_i = 1;
    tick();
    chk_all("clear", 0, 0, 0, 0);
    clear_i = 0;

    // Contention: alternating grants with exactly one IDLE cycle between them.
    req_0_i = 1; req_1_i = 1; burst_len_i = 2;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk_all("rr.grant", 1, 1'(g % 2), 0, 0);
      tick();
      chk_all("rr.beat", 1, 1'(g % 2), 1, 0);
      tick();
      chk_all("rr.gap", 0, 1'(g % 2), 2, 1);
    end
    req_0_i = 0; req_1_i = 0;
    tick();
    chk_all("rr.drop", 0, 1, 2, 0);

    // Backpressure on a burst of 3; request drops right after the grant.
    req_0_i = 1; burst_len_i = 3;
    tick();
    chk_all("bp.grant", 1, 0, 0, 0);
    req_0_i = 0;
    for (int i = 0; i < 5; i++) begin
      pop_ready_i = bp_rdy[i];
      tick();
      chk("bp.cnt", 32'(beat_cnt_o), 32'(bp_cnt[i]));
      chk("bp.locked", 32'(locked_o), (i < 4) ? 32'd1 : 32'd0);
    end
    chk("bp.done", 32'(burst_done_o), 32'd1);
    pop_ready_i = 1;

    // burst_len 0 behaves as a single beat.
    req_1_i = 1; burst_len_i = 0;
    tick();
    chk_all("len0.grant", 1, 1, 0, 0);
    req_1_i = 0;
    tick();
    chk_all("len0.end", 0, 1, 1, 1);

    // Length change mid-grant is ignored.
    req_0_i = 1; burst_len_i = 4;
    tick();
    chk_all("len4.grant", 1, 0, 0, 0);
    req_0_i = 0; burst_len_i = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all("len4.beat", 1, 0, BW'(i), 0);
    end
    tick();
    chk_all("len4.end", 0, 0, 4, 1);

    // Clear together with the final beat wins.
    req_1_i = 1; burst_len_i = 2;
    tick();
    chk_all("clr.grant", 1, 1, 0, 0);
    req_1_i = 0;
    tick();
    chk_all("clr.beat", 1, 1, 1, 0);
    clear_i = 1;
    tick();
    chk_all("clr.final", 0, 0, 0, 0);
    clear_i = 0;
    tick();
    chk_all("clr.after", 0, 0, 0, 0);

    // enable low blocks new grants.
    enable_i = 0; req_0_i = 1;
    tick();
    chk_all("dis.hold", 0, 0, 0, 0);
    tick();
    chk_all("dis.hold2", 0, 0, 0, 0);
    enable_i = 1;

    // Reset mid-LOCK after input 0 won; input 0 must still win first afterwards.
    burst_len_i = 3;
    tick();
    chk_all("rst.grant", 1, 0, 0, 0);
    tick();
    chk_all("rst.beat", 1, 0, 1, 0);
    rst_ni = 0; clear_i = 1; req_1_i = 1;
    tick();
    chk_all("rst.mid", 0, 0, 0, 0);
    rst_ni = 1; clear_i = 0;
    tick();
    chk_all("rst.first", 1, 0, 0, 0);
    req_0_i = 0; req_1_i = 0;
    for (int i = 1; i <= 2; i++) tick();
    tick();
    chk_all("rst.end", 0, 0, 3, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
